// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin ring arbiter.
//   arb_state_t : arbiter FSM states (ST_IDLE = no grant, ST_BUSY = one grant)
//   clog2()     : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2 for sizing counters and indices; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational circular priority picker. Returns the first eligible
// requester (req & mask) found at or after the one-hot ptr position,
// wrapping around the ring.
// Ports:
//   req       in  N  request vector
//   ptr       in  N  one-hot start position (highest priority)
//   mask      in  N  eligibility mask; cleared bits are never picked
//   sel       out N  one-hot pick, zero when nothing is eligible
//   sel_valid out 1  at least one eligible requester
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    input  logic [N-1:0] mask,
    output logic [N-1:0] sel,
    output logic         sel_valid
);

    logic [N-1:0]   eligible;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_pick;

    // Doubling the eligible vector lets a single subtraction find the first
    // set bit at or above ptr: the borrow ripples up from the ptr position
    // and stops at that bit, which is the only bit surviving dbl & ~(dbl-ptr).
    // The two halves are then folded back onto the ring.
    always_comb begin
        eligible  = req & mask;
        dbl       = {eligible, eligible};
        dbl_pick  = dbl & ~(dbl - {{N{1'b0}}, ptr});
        sel       = dbl_pick[N-1:0] | dbl_pick[2*N-1:N];
        sel_valid = |eligible;
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// ---------------------------------------------------------------------------
// rr_ring_arbiter
// Round-robin arbiter sharing one resource between N requesters. Priority
// rotates through a one-hot ring pointer. A grant is held while its owner
// keeps req high, but is pre-empted after MAX_HOLD cycles when others wait.
// Ports:
//   clk       in  1       clock, all state updates on posedge
//   resetn    in  1       asynchronous active-low reset
//   req       in  N       request vector, bit i = requester i
//   gnt       out N       registered one-hot grant, zero when idle
//   gnt_valid out 1       registered |gnt
//   gnt_id    out ID_W    binary index of the granted requester (0 when idle)
//   ptr       out N       one-hot ring priority pointer
//   hold_cnt  out HOLD_W  cycles the current grant has been held, saturating
// ---------------------------------------------------------------------------
module rr_ring_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = clog2(MAX_HOLD + 1),
    parameter int ID_W     = clog2(N)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      gnt,
    output logic              gnt_valid,
    output logic [ID_W-1:0]   gnt_id,
    output logic [N-1:0]      ptr,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_t        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [N-1:0]      ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]      pick_mask;
    logic [N-1:0]      sel;
    logic              sel_valid;
    logic              owner_req;
    logic              others_req;
    logic              issue;

    // While busy the current owner is masked out, so a pre-emption lands on
    // the next requester after it. Since ptr already sits one past the owner,
    // the owner naturally ends up at the lowest priority.
    assign pick_mask  = (state_q == ST_BUSY) ? ~gnt_q : {N{1'b1}};
    assign owner_req  = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);

    rr_pick #(
        .N (N)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .mask      (pick_mask),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    // Next-state logic. An owner drop wins over pre-emption, and a drop with
    // other requests pending hands the grant over on the same edge.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        issue      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    issue = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    if (sel_valid) begin
                        issue = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == MAX_HOLD_C && others_req) begin
                    issue = 1'b1;
                end else if (hold_cnt_q != MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new grant restarts the hold count and rotates the ring pointer
        // to the position just past the winner.
        if (issue) begin
            state_d    = ST_BUSY;
            gnt_d      = sel;
            hold_cnt_d = {{(HOLD_W-1){1'b0}}, 1'b1};
            ptr_d      = {sel[N-2:0], sel[N-1]};
        end

        gnt_valid_d = |gnt_d;
        gnt_id_d    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_d[i]) begin
                gnt_id_d = ID_W'(i);
            end
        end
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= {{(N-1){1'b0}}, 1'b1};
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign ptr       = ptr_q;
    assign hold_cnt  = hold_cnt_q;

endmodule
